// File: rtl/debug_sequencer_if.sv
// debug_sequencer_if: UART command/response handshake between the sequencer and the UART.
// The master modport is the sequencer side; the slave modport is the UART side.
interface debug_sequencer_if;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       tx_done_tick;
    logic       tx_start_o;
    logic [7:0] tx_data_o;
    modport master (input rx_done_tick, rx_data, tx_done_tick, output tx_start_o, tx_data_o);
    modport slave (output rx_done_tick, rx_data, tx_done_tick, input tx_start_o, tx_data_o);
endinterface

// File: rtl/debug_sequencer.sv
// debug_sequencer: run/step control of the pipeline and PC/register(/memory) dump over UART.
// Define DEBUG_MEM_DUMP_EN to append N_MEM_WORDS data memory words to every dump.
module debug_sequencer #(
    parameter int NB_DATA     = 32,
    parameter int NB_PC       = 7,
    parameter int NB_REG      = 5,
    parameter int NB_MEM_ADDR = 7,
    parameter int N_MEM_WORDS = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   finish_rcv,
    debug_sequencer_if.master      uart,
    input  logic                   halt_i,
    output logic                   en_pipeline_o,
    input  logic [NB_PC-1:0]       pc_i,
    output logic [NB_REG-1:0]      reg_addr_o,
    input  logic [NB_DATA-1:0]     reg_data_i,
    output logic [NB_MEM_ADDR-1:0] mem_addr_o,
    input  logic [NB_DATA-1:0]     mem_data_i,
    output logic [2:0]             state_o
);
`ifdef DEBUG_MEM_DUMP_EN
    localparam bit MEM_EN = 1'b1;
`else
    localparam bit MEM_EN = 1'b0;
`endif
    localparam int N_REGS  = 32;
    localparam int N_WORDS = 1 + N_REGS + (MEM_EN ? N_MEM_WORDS : 0);
    localparam int NB_WCNT = $clog2(N_WORDS);
    localparam logic [7:0] CMD_RUN  = 8'h63;
    localparam logic [7:0] CMD_STEP = 8'h73;
    localparam logic [7:0] CMD_DUMP = 8'h64;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_CMD  = 3'd1,
        RUN       = 3'd2,
        STEP      = 3'd3,
        DUMP_ADDR = 3'd4,
        DUMP_CAP  = 3'd5,
        DUMP_TX   = 3'd6,
        HALTED    = 3'd7
    } state_t;

    state_t               state_q, state_d;
    logic                 halted_q, halted_d;
    logic                 busy_q, busy_d;
    logic [1:0]           byte_q, byte_d;
    logic [NB_WCNT-1:0]   word_q, word_d;
    logic [NB_DATA-1:0]   shift_q, shift_d;
    logic [7:0]           cmd;
    logic                 last_word;
    logic [NB_DATA-1:0]   mem_word;

`ifdef DEBUG_MEM_DUMP_EN
    assign mem_word   = mem_data_i;
    assign mem_addr_o = (word_q > NB_WCNT'(N_REGS)) ? NB_MEM_ADDR'(word_q - NB_WCNT'(N_REGS + 1)) : '0;
`else
    logic unused_mem;
    assign unused_mem = ^mem_data_i;
    assign mem_word   = '0;
    assign mem_addr_o = '0;
`endif

    // Address is combinational from the word counter so it leads the capture cycle by one clock.
    assign reg_addr_o      = (word_q != '0 && word_q <= NB_WCNT'(N_REGS)) ? NB_REG'(word_q - NB_WCNT'(1)) : '0;
    assign en_pipeline_o   = (state_q == RUN) || (state_q == STEP);
    assign uart.tx_start_o = (state_q == DUMP_TX) && !busy_q;
    assign uart.tx_data_o  = shift_q[NB_DATA-1 -: 8];
    assign state_o         = state_q;
    assign cmd             = uart.rx_done_tick ? uart.rx_data : 8'h00;
    assign last_word       = word_q == NB_WCNT'(N_WORDS - 1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            halted_q <= 1'b0;
            busy_q   <= 1'b0;
            byte_q   <= '0;
            word_q   <= '0;
            shift_q  <= '0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
            busy_q   <= busy_d;
            byte_q   <= byte_d;
            word_q   <= word_d;
            shift_q  <= shift_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        busy_d   = busy_q;
        byte_d   = byte_q;
        word_d   = word_q;
        shift_d  = shift_q;
        case (state_q)
            IDLE:      state_d = finish_rcv ? WAIT_CMD : IDLE;
            WAIT_CMD:  state_d = (cmd == CMD_RUN) ? RUN : (cmd == CMD_STEP) ? STEP :
                                 (cmd == CMD_DUMP) ? DUMP_ADDR : WAIT_CMD;
            RUN: begin
                state_d  = halt_i ? DUMP_ADDR : RUN;
                halted_d = halted_q | halt_i;
            end
            STEP: begin
                state_d  = DUMP_ADDR;
                halted_d = halted_q | halt_i;
            end
            DUMP_ADDR: state_d = DUMP_CAP;
            DUMP_CAP: begin
                shift_d = (word_q == '0) ? NB_DATA'(pc_i) :
                          (word_q <= NB_WCNT'(N_REGS)) ? reg_data_i : mem_word;
                state_d = DUMP_TX;
            end
            DUMP_TX: begin
                // A byte completes only on tx_done_tick while waiting; the next launch follows a cycle later.
                if (!busy_q) begin
                    busy_d = 1'b1;
                end else if (uart.tx_done_tick) begin
                    busy_d  = 1'b0;
                    shift_d = shift_q << 8;
                    byte_d  = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        word_d  = last_word ? '0 : word_q + NB_WCNT'(1);
                        state_d = !last_word ? DUMP_ADDR : halted_q ? HALTED : WAIT_CMD;
                    end
                end
            end
            HALTED:    state_d = (cmd == CMD_DUMP) ? DUMP_ADDR : HALTED;
            default:   state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_debug_sequencer.sv
// tb_debug_sequencer: scoreboard bench; expected dump bytes are queued when a command is issued
// and a monitor pops and compares them on every tx_start_o pulse.
module tb_debug_sequencer;
`ifdef DEBUG_MEM_DUMP_EN
    localparam int FRAME = 260;
`else
    localparam int FRAME = 132;
`endif
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        finish_rcv = 1'b0;
    logic        halt_i = 1'b0;
    logic [6:0]  pc_i = '0;
    logic        en_pipeline_o;
    logic [4:0]  reg_addr_o;
    logic [31:0] reg_data_i = '0;
    logic [6:0]  mem_addr_o;
    logic [31:0] mem_data_i = '0;
    logic [2:0]  state_o;
    logic [31:0] rf [32];
    logic [31:0] mem [128];
    logic [7:0]  sb [$];
    int total = 0, bad = 0, pulses = 0, en_cycles = 0, mem_max = 0;
    int e0, p0;

    debug_sequencer_if u_if ();

    debug_sequencer dut (
        .clock(clock), .reset(reset), .finish_rcv(finish_rcv), .uart(u_if.master),
        .halt_i(halt_i), .en_pipeline_o(en_pipeline_o), .pc_i(pc_i),
        .reg_addr_o(reg_addr_o), .reg_data_i(reg_data_i),
        .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i), .state_o(state_o)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        reg_data_i <= rf[reg_addr_o];
        mem_data_i <= mem[mem_addr_o];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [6:0] pc);
        logic [31:0] w;
        for (int i = 0; i < FRAME / 4; i++) begin
            w = (i == 0) ? {25'b0, pc} : (i <= 32) ? rf[i-1] : mem[i-33];
            for (int b = 3; b >= 0; b--) sb.push_back(w[b*8 +: 8]);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clock);
        u_if.rx_data = b;
        u_if.rx_done_tick = 1'b1;
        @(negedge clock);
        u_if.rx_done_tick = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s);
        int n = 0;
        while (state_o !== s && n < 5000) begin
            @(negedge clock);
            n++;
        end
        chk("wait_state", {29'b0, state_o}, {29'b0, s});
    endtask

    task automatic dump_done(input string name, input int en_exp);
        chk({name, "_en_cycles"}, en_cycles - e0, en_exp);
        chk({name, "_pulses"}, pulses - p0, FRAME);
        chk({name, "_sb_empty"}, sb.size(), 0);
    endtask

    // UART transmitter model: done strobe three cycles after each start, data must be held meanwhile.
    initial begin
        int cnt = 0;
        logic [7:0] held = '0;
        u_if.tx_done_tick = 1'b0;
        forever begin
            @(negedge clock);
            u_if.tx_done_tick = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    chk("tx_hold", {24'b0, u_if.tx_data_o}, {24'b0, held});
                    u_if.tx_done_tick = 1'b1;
                end
            end
            if (u_if.tx_start_o) begin
                cnt = 3;
                held = u_if.tx_data_o;
            end
        end
    end

    initial begin
        logic [7:0] exp;
        forever begin
            @(negedge clock);
            if (en_pipeline_o) en_cycles++;
            if (int'(mem_addr_o) > mem_max) mem_max = int'(mem_addr_o);
            if (u_if.tx_start_o) begin
                pulses++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_unexpected got=%h exp=none t=%0t", u_if.tx_data_o, $time);
                end else begin
                    exp = sb.pop_front();
                    chk("tx_byte", {24'b0, u_if.tx_data_o}, {24'b0, exp});
                end
            end
        end
    end

    initial begin
        u_if.rx_done_tick = 1'b0;
        u_if.rx_data = '0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h1020_3040 + i * 32'h0101_0101;
        rf[5] = 32'hDEAD_BEEF;
        for (int i = 0; i < 128; i++) mem[i] = 32'hA500_0000 | i;
        repeat (3) @(negedge clock);
        chk("rst_state", {29'b0, state_o}, 0);
        chk("rst_en", {31'b0, en_pipeline_o}, 0);
        chk("rst_tx_start", {31'b0, u_if.tx_start_o}, 0);
        chk("rst_tx_data", {24'b0, u_if.tx_data_o}, 0);
        chk("rst_reg_addr", {27'b0, reg_addr_o}, 0);
        chk("rst_mem_addr", {25'b0, mem_addr_o}, 0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("idle_hold", {29'b0, state_o}, 0);
        finish_rcv = 1'b1;
        @(negedge clock);
        chk("to_wait", {29'b0, state_o}, 1);
        finish_rcv = 1'b0;
        repeat (2) @(negedge clock);
        chk("finish_drop", {29'b0, state_o}, 1);

        send(8'h63);
        chk("run_state", {29'b0, state_o}, 2);
        chk("run_en", {31'b0, en_pipeline_o}, 1);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("rrst_state", {29'b0, state_o}, 0);
        chk("rrst_en", {31'b0, en_pipeline_o}, 0);
        chk("rrst_tx_start", {31'b0, u_if.tx_start_o}, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("rrst_idle", {29'b0, state_o}, 0);
        finish_rcv = 1'b1;
        @(negedge clock);
        chk("rrst_wait", {29'b0, state_o}, 1);
        finish_rcv = 1'b0;

        p0 = pulses;
        send(8'h41);
        send(8'h00);
        send(8'h43);
        send(8'hFF);
        chk("undef_state", {29'b0, state_o}, 1);
        chk("undef_no_tx", pulses - p0, 0);

        pc_i = 7'h04;
        e0 = en_cycles;
        p0 = pulses;
        push_frame(pc_i);
        send(8'h73);
        chk("step_state", {29'b0, state_o}, 3);
        chk("step_en", {31'b0, en_pipeline_o}, 1);
        @(negedge clock);
        chk("step_en_off", {31'b0, en_pipeline_o}, 0);
        wait_state(3'd1);
        dump_done("step", 1);

        pc_i = 7'h11;
        e0 = en_cycles;
        p0 = pulses;
        push_frame(pc_i);
        send(8'h64);
        chk("dump_state", {29'b0, state_o}, 4);
        repeat (100) @(negedge clock);
        send(8'h73);
        send(8'h63);
        chk("dump_busy_en", {31'b0, en_pipeline_o}, 0);
        wait_state(3'd1);
        dump_done("dump", 0);

        pc_i = 7'h2C;
        e0 = en_cycles;
        p0 = pulses;
        send(8'h63);
        repeat (49) @(negedge clock);
        halt_i = 1'b1;
        u_if.rx_data = 8'h73;
        u_if.rx_done_tick = 1'b1;
        @(negedge clock);
        halt_i = 1'b0;
        u_if.rx_done_tick = 1'b0;
        push_frame(pc_i);
        chk("halt_en_off", {31'b0, en_pipeline_o}, 0);
        chk("halt_state", {29'b0, state_o}, 4);
        wait_state(3'd7);
        dump_done("halt", 50);

        e0 = en_cycles;
        p0 = pulses;
        send(8'h73);
        send(8'h63);
        repeat (40) @(negedge clock);
        chk("halted_state", {29'b0, state_o}, 7);
        chk("halted_no_en", en_cycles - e0, 0);
        chk("halted_no_tx", pulses - p0, 0);

        e0 = en_cycles;
        p0 = pulses;
        push_frame(pc_i);
        send(8'h64);
        chk("redump_state", {29'b0, state_o}, 4);
        wait_state(3'd7);
        dump_done("redump", 0);
`ifdef DEBUG_MEM_DUMP_EN
        chk("mem_addr_max", mem_max, 31);
`else
        chk("mem_addr_zero", mem_max, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/debug_sequencer.md
# debug_sequencer

Run-control and state-dump controller between the UART and the five-stage MIPS pipeline. After program load it accepts single-byte host commands. It either runs the pipeline continuously until a halt instruction retires, or advances it one clock per step. After every step or halt it streams a snapshot over UART TX: PC, register file, and optionally data memory. It replaces the fixed enable-after-load behaviour of the current debug unit.

## Interface
Parameters:
- NB_DATA, 32, datapath word width
- NB_PC, 7, program counter width
- NB_REG, 5, register address width
- NB_MEM_ADDR, 7, data memory word address width
- N_MEM_WORDS, 32, data memory words dumped (≤ 2^NB_MEM_ADDR)

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- finish_rcv  in  1  program load complete (level)
- rx_done_tick  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  received command byte
- tx_done_tick  in  1  one-cycle strobe, previous TX byte finished
- tx_start_o  out  1  one-cycle strobe, launch tx_data_o
- tx_data_o  out  8  byte to transmit
- halt_i  in  1  halt instruction in WB this cycle
- en_pipeline_o  out  1  pipeline/stage-register enable
- pc_i  in  NB_PC  current fetch PC
- reg_addr_o  out  NB_REG  register file debug read address
- reg_data_i  in  NB_DATA  register data, 1-cycle read latency
- mem_addr_o  out  NB_MEM_ADDR  data memory debug read address
- mem_data_i  in  NB_DATA  memory data, 1-cycle read latency
- state_o  out  3  current FSM state encoding

## Operation
- Commands (all others ignored): 0x63 'c' continuous run; 0x73 's' single step; 0x64 'd' dump without advancing.
- Commands are accepted only in WAIT_CMD or HALTED. Bytes arriving in any other state are dropped.
- FSM states:
  - IDLE: waits for finish_rcv=1, then goes to WAIT_CMD.
  - WAIT_CMD: 'c' goes to RUN, 's' goes to STEP, 'd' goes to DUMP.
  - RUN: en_pipeline_o=1 until halt_i=1, then goes to DUMP and latches halted flag.
  - STEP: en_pipeline_o=1 for exactly one cycle, then goes to DUMP. If halt_i=1 in that cycle, the halted flag is set.
  - DUMP: loads the next word, then sends it as 4 bytes, MSB first.
  - After the last byte: goes to HALTED if the halted flag is set, else to WAIT_CMD.
  - HALTED: only 'd' is accepted (re-dump). 'c' and 's' are ignored until reset.
- Dump order:
  - PC word, zero-extended to NB_DATA.
  - Registers 0..31.
  - Memory words 0..N_MEM_WORDS-1, only if DEBUG_MEM_DUMP_EN is defined.
- Byte counter: 2 bits within a word. Word counter: sized for 1+32+N_MEM_WORDS, no wrap; the terminal count ends the dump.
- en_pipeline_o=0 in every state except RUN and the single STEP cycle.
- reg_addr_o and mem_addr_o are valid one cycle before the corresponding word is latched into a 32-bit shift register.

## Timing
- Reset values: state IDLE, en_pipeline_o=0, tx_start_o=0, tx_data_o=0x00, reg_addr_o=0, mem_addr_o=0, halted flag=0, counters=0.
- Command latency: from the rx_done_tick cycle to en_pipeline_o=1 is 1 clock.
- Halt response: en_pipeline_o falls on the clock edge after the halt_i=1 cycle. The pipeline advances exactly once in the cycle halt_i is seen.
- Word load: 2 cycles (address, then capture). The first tx_start_o for a word follows the capture by 1 cycle.
- Byte handshake:
  - tx_start_o pulses once per byte, and tx_data_o is held stable until tx_done_tick.
  - The next tx_start_o is issued ≥1 cycle after tx_done_tick.
  - tx_done_tick outside a send wait is ignored.
- Simultaneous halt_i and rx_done_tick in RUN: halt wins and the byte is dropped.
- finish_rcv deasserting after IDLE has no effect.
- Reset mid-dump or mid-run: returns to IDLE in the next cycle. tx_start_o=0 and en_pipeline_o=0 immediately, and the partial frame is abandoned.

## Configuration
- DEBUG_MEM_DUMP_EN defined:
  - Frame = 4 + 128 + 4·N_MEM_WORDS bytes (260 at defaults).
  - mem_addr_o sweeps 0..N_MEM_WORDS-1.
- DEBUG_MEM_DUMP_EN undefined:
  - Frame = 132 bytes (PC + registers).
  - mem_addr_o tied to 0 and mem_data_i unused.

## Test plan
- Reset during RUN with en_pipeline_o=1 → next cycle state IDLE, en_pipeline_o=0, tx_start_o=0. A subsequent finish_rcv returns to WAIT_CMD.
- finish_rcv=1, send 's' with pc_i=0x04 → en_pipeline_o high for exactly 1 cycle. Then 260 tx_start_o pulses, and the first 4 bytes are 0x00,0x00,0x00,0x04. Ends in WAIT_CMD.
- Send 'c', assert halt_i at cycle 50 → en_pipeline_o low from cycle 51. Full dump follows and the FSM ends in HALTED. Then 's' produces no enable and no TX.
- In HALTED send 'd' with r5=0xDEADBEEF → bytes 24..27 of the frame are 0xDE,0xAD,0xBE,0xEF, and en_pipeline_o stays 0.
- Send 0x41 and other undefined bytes in WAIT_CMD, and 's' during a dump → no state change, the dump completes unaltered.
- Build without DEBUG_MEM_DUMP_EN, send 'd' → exactly 132 tx_start_o pulses and mem_addr_o constant 0.
